pipe_reg_chain: RTL
===================

# pipe_reg_chain

Parametrised chain of pipeline registers with per-stage valid bits, stall, flush and bubble insertion. It replaces the fixed, stall-less inter-stage registers of the pipelined MIPS datapath (F/D, D/E, E/M, M/WB) with one generic block. The hazard unit drives `stall_i` and `flush_i`, and the datapath packs each stage's data and control fields into the stage data vectors.

## Interface
- `DATA_W`, default 32: payload width per stage.
- `STAGES`, default 4: number of register stages. Legal range is 1..16.
- `CNT_W`, default 16: width of the performance counters. Used only when `PIPE_CHAIN_PERF_EN` is defined.

Ports:
- `clk_i`  in  1  clock. Every register is rising-edge.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `in_valid_i`  in  1  stage-0 input is a real instruction.
- `in_data_i`  in  DATA_W  stage-0 input payload.
- `in_ready_o`  out  1  stage 0 loads at the next edge (equals `~hold[0]`).
- `stall_i`  in  STAGES  bit k: stage k holds its content.
- `flush_i`  in  STAGES  bit k: the content entering stage k is killed.
- `stage_valid_o`  out  STAGES  valid bit of every stage.
- `stage_data_o`  out  STAGES*DATA_W  payload of every stage. Stage k occupies bits `[k*DATA_W +: DATA_W]`.
- `out_valid_o`  out  1  `stage_valid_o[STAGES-1]`.
- `out_data_o`  out  DATA_W  payload of the last stage.
- `stall_cnt_o`, `bubble_cnt_o`, `flush_cnt_o`  out  CNT_W each  performance counters. Present only with `PIPE_CHAIN_PERF_EN`.

## Operation
- `hold[k] = |stall_i[STAGES-1:k]`. A stall in stage k freezes stage k and every upstream stage.
- Next state of stage k, evaluated in priority order:
  1. `flush_i[k]`: valid <= 0; data keeps its current value.
  2. `hold[k]`: valid and data unchanged.
  3. k == 0: valid <= `in_valid_i`, data <= `in_data_i`.
  4. `hold[k-1]`: the stage receives a bubble. valid <= 0; data unchanged.
  5. Otherwise: valid and data <= stage k-1.
- Flush outranks stall on the same stage. The result is valid 0 with the data frozen.
- Flushing stage k does not affect stage k+1. The old content of stage k still advances into k+1 when stage k+1 is not held.
- Invalid entries move exactly like valid ones. The block never collapses bubbles.
- The block applies no data gating. Consumers must qualify every stage's data with its valid bit.
- `STAGES == 1`: `hold[0] = stall_i[0]` and there is no bubble rule.

## Timing
- Reset values: every valid bit 0, every data register 0, `out_valid_o` 0, `in_ready_o = ~|stall_i`, all counters 0.
- Reset acts immediately. Asserting it mid-stream clears the whole chain within the same cycle; no edge is needed.
- Latency: an entry accepted at edge n appears on `out_*` after edge n+STAGES-1, provided nothing stalls.
- Throughput: one entry per cycle.
- `in_ready_o` and `hold` are combinational from `stall_i`. No register sits in the stall path.
- `flush_i` and `stall_i` are sampled at the same edge as the data movement.
- The block adds no extra cycle of latency.

## Configuration
- `PIPE_CHAIN_PERF_EN` defined: the three counters are compiled in. Each saturates at all-ones and none wraps.
  - `stall_cnt_o` increments on every cycle with `|stall_i`.
  - `bubble_cnt_o` increments once per cycle in which at least one stage applies rule 4.
  - `flush_cnt_o` increments once per cycle with `|flush_i`.
- `PIPE_CHAIN_PERF_EN` undefined: the counter ports and logic are absent, and the block is purely the register chain.

## Test plan
- Stream test (STAGES=4, DATA_W=32).
  - Stimulus: reset, then drive `in_valid_i=1` with data 0x10, 0x11, 0x12, ... on consecutive cycles.
  - Required: 0x10 appears on `out_data_o` with `out_valid_o=1` three edges after it was accepted. The sequence that follows is contiguous, in order, with no gaps.
- Mid-chain stall.
  - Stimulus: streaming as above; hold `stall_i=4'b0010` for 2 cycles.
  - Required: `in_ready_o=0` for exactly those 2 cycles, and stages 0 and 1 freeze. Stage 2 receives 2 bubbles, so `out_valid_o` shows a 2-cycle gap. Nothing is lost or duplicated.
- Branch flush.
  - Stimulus: pulse `flush_i=4'b0011` for 1 cycle while streaming.
  - Required: the two entries entering stages 0 and 1 never reach the output (`out_valid_o` gap of 2). The entry already in stage 1 still advances to stage 2.
- Flush + stall on the same stage.
  - Stimulus: `stall_i[1]=1` and `flush_i[1]=1` in the same cycle.
  - Required: `stage_valid_o[1]=0` next cycle, `stage_data_o` slice 1 unchanged, and stage 0 holds.
- Reset mid-operation.
  - Stimulus: full pipe; assert `reset_i` between edges.
  - Required: every `stage_valid_o` goes to 0 and all data goes to 0 before the next edge. The first entry accepted after release emerges with latency 3.
- Counters (with `PIPE_CHAIN_PERF_EN`, CNT_W=4).
  - Stimulus: 20 stall cycles, then 3 flush cycles.
  - Required: `stall_cnt_o=4'hF` (saturated), `flush_cnt_o=3`, and `bubble_cnt_o` equal to the number of stall cycles with `hold[0]!=hold[1]`-type boundaries.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Generic pipeline register chain with per-stage valid, stall, flush and bubble insertion.
// Define PIPE_CHAIN_PERF_EN to compile in saturating stall/bubble/flush counters.
module pipe_reg_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    input  logic [DATA_W-1:0]        in_data_i,
    output logic                     in_ready_o,
    input  logic [STAGES-1:0]        stall_i,
    input  logic [STAGES-1:0]        flush_i,
    output logic [STAGES-1:0]        stage_valid_o,
    output logic [STAGES*DATA_W-1:0] stage_data_o,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        out_data_o
`ifdef PIPE_CHAIN_PERF_EN
    ,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o,
    output logic [CNT_W-1:0]         flush_cnt_o
`endif
);

    if ((STAGES < 1) || (STAGES > 16) || (CNT_W < 1)) begin : g_bad_param
        $error("pipe_reg_chain: STAGES must be 1..16 and CNT_W at least 1");
    end

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] data_p   [STAGES];
    logic [STAGES-1:0] vld_nxt;
    logic [DATA_W-1:0] data_nxt [STAGES];
    logic [STAGES-1:0] src_vld;
    logic [DATA_W-1:0] src_data [STAGES];
    logic [STAGES-1:0] src_hold;

    // A stall anywhere downstream freezes this stage too, so hold is a suffix-OR.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall_i[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            hold[k] = stall_i[k] | hold[k+1];
        end
    end

    assign in_ready_o = ~hold[0];

    // Stage 0 sources from the input port and is never starved by an upstream hold.
    always_comb begin
        src_vld     = '0;
        src_hold    = '0;
        src_vld[0]  = in_valid_i;
        src_data[0] = in_data_i;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k]  = vld_p[k-1];
            src_data[k] = data_p[k-1];
            src_hold[k] = hold[k-1];
        end
    end

    always_comb begin
        vld_nxt = vld_p;
        for (int k = 0; k < STAGES; k++) begin
            data_nxt[k] = data_p[k];
            if (flush_i[k]) begin
                vld_nxt[k] = 1'b0;
            end else if (hold[k]) begin
                vld_nxt[k] = vld_p[k];
            end else if (src_hold[k]) begin
                vld_nxt[k] = 1'b0;
            end else begin
                vld_nxt[k]  = src_vld[k];
                data_nxt[k] = src_data[k];
            end
        end
    end

    // ---- register stage boundary ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_p[k] <= '0;
            end
        end else begin
            vld_p <= vld_nxt;
            for (int k = 0; k < STAGES; k++) begin
                data_p[k] <= data_nxt[k];
            end
        end
    end

    always_comb begin
        stage_data_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_data_o[k*DATA_W +: DATA_W] = data_p[k];
        end
    end

    assign stage_valid_o = vld_p;
    assign out_valid_o   = vld_p[STAGES-1];
    assign out_data_o    = data_p[STAGES-1];

`ifdef PIPE_CHAIN_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != '1)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    logic [STAGES-1:0] bubble;

    // A bubble is a stage that is free to load but whose upstream neighbour is held.
    always_comb begin
        bubble = '0;
        for (int k = 0; k < STAGES; k++) begin
            bubble[k] = ~flush_i[k] & ~hold[k] & src_hold[k];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            stall_cnt_o  <= sat_inc(stall_cnt_o, |stall_i);
            bubble_cnt_o <= sat_inc(bubble_cnt_o, |bubble);
            flush_cnt_o  <= sat_inc(flush_cnt_o, |flush_i);
        end
    end
`endif

endmodule
